// File: rtl/mem_wait_ram.sv
// mem_wait_ram: single-port word RAM with a fixed number of wait states per
// access. An access is accepted in IDLE, waits WAIT cycles in BUSY, completes
// on the following edge and signals completion with a one-cycle ready pulse.
// Optional feature: define MEM_WAIT_RAM_PARITY_EN to store an even-parity bit
// with every word and flag parity mismatches on read completion.
module mem_wait_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_WAIT_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;  // data in [DATA_W-1:0], parity in [DATA_W]
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic [MEM_W-1:0]  memory [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;
  logic              w_done;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;
  logic [MEM_W-1:0]  w_mem_word;
  logic [MEM_W-1:0]  w_wr_word;

  assign w_mem_word = memory[r_addr];

`ifdef MEM_WAIT_RAM_PARITY_EN
  assign w_wr_word = {even_par(r_wdata), r_wdata};
`else
  assign w_wr_word = r_wdata;
`endif

  // Next-state logic: accept in IDLE, count down wait states, complete at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = WAIT_CNT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, wait counter, request latch, completion pulse and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_done;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_done && !r_we) begin
        r_rdata <= w_mem_word[DATA_W-1:0];
      end
    end
  end

  // Storage write on write completion; contents are never reset, and an
  // access aborted by reset never reaches completion.
  always_ff @(posedge clk) begin
    if (!rst && w_done && r_we) begin
      memory[r_addr] <= w_wr_word;
    end
  end

`ifdef MEM_WAIT_RAM_PARITY_EN
  logic r_perr;
  logic w_rd_perr;

  assign w_rd_perr = w_mem_word[DATA_W] ^ even_par(w_mem_word[DATA_W-1:0]);

  // Parity flag is updated only when a read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_done && !r_we) begin
      r_perr <= w_rd_perr;
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign busy  = (r_state == ST_BUSY);

endmodule

// File: doc/mem_wait_ram.md
MEM_WAIT_RAM -- requirements
Module: mem_wait_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter WAIT, default 2, wait states per access; legal range 0..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr  input  ADDR_W  word address; sampled with req.
REQ-009 SHALL have port wdata  input  DATA_W  write data; sampled with req.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high while an accepted access is in progress.
REQ-013 SHALL have port parity_err  output  1  registered parity mismatch flag for the last read.

Function
REQ-014 SHALL hold storage in an array named memory, 2**ADDR_W entries, with no reset of its contents.
REQ-015 SHALL implement states IDLE and BUSY with a wait counter cnt of 4 bits.
REQ-016 SHALL, in IDLE with req=1 at a rising edge, latch we/addr/wdata, load cnt<=WAIT and enter BUSY; req=0 keeps IDLE.
REQ-017 SHALL, in BUSY with cnt!=0, decrement cnt each edge; req is ignored in BUSY.
REQ-018 SHALL, in BUSY with cnt==0, perform the access at that edge, set ready<=1 for exactly one cycle and return to IDLE.
REQ-019 SHALL give latency: req sampled at edge E0 -> ready high during the cycle after edge E(WAIT+1).
REQ-020 SHALL, on a read completion, load rdata<=memory[addr latched]; rdata SHALL hold until the next read completes.
REQ-021 SHALL, on a write completion, update memory[addr latched] and leave rdata and parity_err unchanged.
REQ-022 SHALL allow acceptance of a new req in the cycle ready is high (state is IDLE), giving a back-to-back throughput of one access per WAIT+2 cycles.
REQ-023 SHALL drive busy=1 exactly when the state is BUSY.
REQ-024 SHALL treat all addresses as in range (ADDR_W bits wrap naturally); a read-after-write to the same address SHALL return the written value.

Reset
REQ-025 SHALL, on rst=1, immediately force state IDLE, cnt=0, ready=0, busy=0, rdata=0, parity_err=0.
REQ-026 SHALL, on rst asserted mid-access, abort the access with no memory write and no ready pulse.
REQ-027 SHALL accept a new req on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro MEM_WAIT_RAM_PARITY_EN defined, store DATA_W+1 bits per word including an even-parity bit computed from wdata on write.
REQ-029 SHALL, with MEM_WAIT_RAM_PARITY_EN defined, set parity_err on read completion to 1 iff the stored parity bit mismatches the XOR of the stored data bits, else 0.
REQ-030 SHALL, without MEM_WAIT_RAM_PARITY_EN, store DATA_W bits per word and tie parity_err to constant 0.

Verification
REQ-031 SHALL cover: WAIT=2, write 0xBEEF to 0x10 then read 0x10 -> ready exactly 3 edges after each accept, rdata=0xBEEF, busy high 3 cycles per access.
REQ-032 SHALL cover: WAIT=0, back-to-back reads of preloaded 0x0001,0x0002 at 0x00,0x01 with req held high -> ready every 2nd cycle, rdata 0x0001 then 0x0002.
REQ-033 SHALL cover: req pulsed while busy=1 -> ignored; exactly one ready pulse per accepted request.
REQ-034 SHALL cover: rst asserted mid-write of 0x1234 to 0x05 (memory[0x05]=0xAAAA) -> no ready, memory[0x05] still 0xAAAA, all outputs 0 immediately.
REQ-035 SHALL cover: parity enabled, write 0x00FF to 0x20, bench flips data bit 0 of memory[0x20] -> read gives rdata=0x00FE, parity_err=1; subsequent clean read gives parity_err=0.
REQ-036 SHALL cover: addr=0xFF write 0x5555 then read 0xFF with ADDR_W=8 -> rdata=0x5555, no aliasing into 0x00.
